// File: rtl/yuv_csc_sram_stage.sv
// YUV 4:4:4 to RGB888 conversion stage: reads Y/U/V planes from SRAM, writes
// packed RGB words back, one pixel pair per 9-cycle pass.
module yuv_csc_sram_stage #(
    parameter logic [17:0] Y_BASE    = 18'd0,
    parameter logic [17:0] U_BASE    = 18'd38400,
    parameter logic [17:0] V_BASE    = 18'd57600,
    parameter logic [17:0] RGB_BASE  = 18'd146944,
    parameter logic [17:0] NUM_PAIRS = 18'd19200
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_Y, S_RD_U, S_RD_V, S_CAP_U, S_CAP_V,
        S_CALC, S_WR0, S_WR1, S_WR2, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] k_q, k_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] y_q, y_d, u_q, u_d, v_q, v_d;
    // R0/G0 go straight into the write-data register; only the later bytes are held.
    logic [31:0] rgb_q, rgb_d;
    logic [23:0] pix0, pix1;

    function automatic logic [7:0] clamp8(input logic signed [31:0] acc);
        logic signed [31:0] sh;
        sh = acc >>> 16;
        if (sh < 32'sd0)
            return '0;
        else if (sh > 32'sd255)
            return '1;
        else
            return sh[7:0];
    endfunction

    function automatic logic [23:0] yuv2rgb(input logic [7:0] y8, input logic [7:0] u8,
                                            input logic [7:0] v8);
        logic signed [31:0] y, u, v;
        y = $signed({24'd0, y8}) - 32'sd16;
        u = $signed({24'd0, u8}) - 32'sd128;
        v = $signed({24'd0, v8}) - 32'sd128;
        return {clamp8(32'sd76284 * y + 32'sd104595 * v),
                clamp8(32'sd76284 * y - 32'sd25624 * u - 32'sd53281 * v),
                clamp8(32'sd76284 * y + 32'sd132251 * u)};
    endfunction

    assign pix0 = yuv2rgb(y_q[15:8], u_q[15:8], v_q[15:8]);
    assign pix1 = yuv2rgb(y_q[7:0],  u_q[7:0],  v_q[7:0]);

    // Outputs are registered, so each branch loads the values for the state being entered.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        done_d  = 1'b0;
        y_d     = y_q;
        u_d     = u_q;
        v_d     = v_q;
        rgb_d   = rgb_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RD_Y;
                    k_d     = '0;
                    addr_d  = Y_BASE;
                end
            end
            S_RD_Y: begin
                state_d = S_RD_U;
                addr_d  = U_BASE + k_q;
            end
            S_RD_U: begin
                state_d = S_RD_V;
                addr_d  = V_BASE + k_q;
            end
            S_RD_V: begin
                state_d = S_CAP_U;
                y_d     = SRAM_read_data;
            end
            S_CAP_U: begin
                state_d = S_CAP_V;
                u_d     = SRAM_read_data;
            end
            S_CAP_V: begin
                state_d = S_CALC;
                v_d     = SRAM_read_data;
            end
            S_CALC: begin
                state_d = S_WR0;
                rgb_d   = {pix0[7:0], pix1};
                addr_d  = RGB_BASE + k_q + {k_q[16:0], 1'b0};
                wdata_d = pix0[23:8];
                we_n_d  = 1'b0;
            end
            S_WR0: begin
                state_d = S_WR1;
                addr_d  = addr_q + 18'd1;
                wdata_d = rgb_q[31:16];
                we_n_d  = 1'b0;
            end
            S_WR1: begin
                state_d = S_WR2;
                addr_d  = addr_q + 18'd1;
                wdata_d = rgb_q[15:0];
                we_n_d  = 1'b0;
            end
            S_WR2: begin
                if (k_q == NUM_PAIRS - 18'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RD_Y;
                    k_d     = k_q + 18'd1;
                    addr_d  = Y_BASE + k_q + 18'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = busy_q;
    assign Done            = done_q;

endmodule

// File: tb/tb_yuv_csc_sram_stage.sv
// Directed bench for yuv_csc_sram_stage: SRAM read model with 2-cycle latency,
// write scoreboard, cycle-exact timing and reset checks.
module tb_yuv_csc_sram_stage;

    localparam logic [17:0] Y_B   = 18'd0;
    localparam logic [17:0] U_B   = 18'd38400;
    localparam logic [17:0] V_B   = 18'd57600;
    localparam logic [17:0] RGB_B = 18'h3FFF6;
    localparam logic [17:0] NP    = 18'd4;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data = '0;

    always #10 Clock = ~Clock;

    yuv_csc_sram_stage #(
        .Y_BASE(Y_B), .U_BASE(U_B), .V_BASE(V_B), .RGB_BASE(RGB_B), .NUM_PAIRS(NP)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Busy(Busy), .Done(Done),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
    );

    logic [15:0] mem [logic [17:0]];
    logic [15:0] rd_pipe = '0;

    always @(posedge Clock) begin
        rd_pipe        <= mem.exists(SRAM_address) ? mem[SRAM_address] : 16'hDEAD;
        SRAM_read_data <= rd_pipe;
    end

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wcnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clampf(input int acc);
        int s;
        s = acc >>> 16;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    function automatic logic [23:0] model(input logic [7:0] y, input logic [7:0] u,
                                          input logic [7:0] v);
        int yy, uu, vv;
        yy = int'(y) - 16;
        uu = int'(u) - 128;
        vv = int'(v) - 128;
        return {clampf(76284 * yy + 104595 * vv),
                clampf(76284 * yy - 25624 * uu - 53281 * vv),
                clampf(76284 * yy + 132251 * uu)};
    endfunction

    task automatic load_pair(input int k, input logic [15:0] yw, input logic [15:0] uw,
                             input logic [15:0] vw);
        mem[Y_B + 18'(k)] = yw;
        mem[U_B + 18'(k)] = uw;
        mem[V_B + 18'(k)] = vw;
    endtask

    task automatic push_words(input int k, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2);
        wr_t e;
        logic [17:0] a;
        a = RGB_B + 18'(3 * k);
        e.a = a;          e.d = w0; exp_q.push_back(e);
        e.a = a + 18'd1;  e.d = w1; exp_q.push_back(e);
        e.a = a + 18'd2;  e.d = w2; exp_q.push_back(e);
    endtask

    task automatic push_model(input int k);
        logic [15:0] yw, uw, vw;
        logic [23:0] p0, p1;
        yw = mem[Y_B + 18'(k)];
        uw = mem[U_B + 18'(k)];
        vw = mem[V_B + 18'(k)];
        p0 = model(yw[15:8], uw[15:8], vw[15:8]);
        p1 = model(yw[7:0], uw[7:0], vw[7:0]);
        push_words(k, p0[23:8], {p0[7:0], p1[23:16]}, p1[15:0]);
    endtask

    task automatic observe(input int c);
        int p, k;
        logic [17:0] ra;
        wr_t e;
        p = (c - 1) % 9;
        k = (c - 1) / 9;
        if (!SRAM_we_n) begin
            wcnt++;
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(SRAM_address), 32'(e.a));
                check("wr_data", 32'(SRAM_write_data), 32'(e.d));
            end
        end
        if (c <= 36) begin
            check("busy_run", 32'(Busy), 32'd1);
            check("done_run", 32'(Done), 32'd0);
            check("we_n_phase", 32'(SRAM_we_n), (p >= 6) ? 32'd0 : 32'd1);
            if (p <= 2) begin
                ra = (p == 0) ? Y_B : ((p == 1) ? U_B : V_B);
                check("rd_addr", 32'(SRAM_address), 32'(ra + 18'(k)));
            end
        end else if (c == 37) begin
            check("done_pulse", 32'(Done), 32'd1);
            check("busy_done", 32'(Busy), 32'd1);
            check("we_n_done", 32'(SRAM_we_n), 32'd1);
        end else begin
            check("busy_idle", 32'(Busy), 32'd0);
            check("done_idle", 32'(Done), 32'd0);
            check("we_n_idle", 32'(SRAM_we_n), 32'd1);
        end
    endtask

    // Called right after a falling edge; abort_c > 0 returns after that cycle's checks.
    task automatic run(input int abort_c, input bit mid_start);
        wcnt  = 0;
        Start = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            @(negedge Clock);
            if (c == 1) Start = 1'b0;
            observe(c);
            if (c == abort_c) return;
            if (mid_start && c == 5) Start = 1'b1;
            if (c == 6) Start = 1'b0;
            if (c == 37) Start = 1'b1;
            if (c == 38) Start = 1'b0;
        end
        check("we_low_cycles", 32'(wcnt), 32'd12);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(SRAM_address), 32'd0);
        check({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
        check({tag, "_we_n"}, 32'(SRAM_we_n), 32'd1);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        load_pair(0, 16'hEBEB, 16'h8080, 16'h8080);
        load_pair(1, 16'h10FF, 16'h8080, 16'h80FF);
        load_pair(2, 16'h1010, 16'h8080, 16'h0000);
        load_pair(3, 16'h3CA0, 16'h5AC8, 16'hE128);
        repeat (2) @(negedge Clock);
        check_reset_outputs("por");
        Resetn = 1'b1;
        @(negedge Clock);
        check("idle_busy", 32'(Busy), 32'd0);

        // Run A: known vectors, wrap of RGB addresses, Start re-pulsed while busy and at Done
        push_words(0, 16'hFEFE, 16'hFEFE, 16'hFEFE);
        push_words(1, 16'h0000, 16'h00FF, 16'hAEFF);
        push_words(2, 16'h0068, 16'h0000, 16'h6800);
        push_model(3);
        run(0, 1'b1);

        // Run B: random data, reset asserted in the middle of the second write
        for (int k = 0; k < 4; k++)
            load_pair(k, 16'($urandom), 16'($urandom), 16'($urandom));
        for (int k = 0; k < 4; k++) push_model(k);
        run(8, 1'b0);
        #2 Resetn = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        repeat (3) begin
            @(negedge Clock);
            check("rst_hold_done", 32'(Done), 32'd0);
            check("rst_hold_busy", 32'(Busy), 32'd0);
        end
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_rst_idle", 32'(Busy), 32'd0);

        // Run C: restart must begin again at pair 0
        for (int k = 0; k < 4; k++) push_model(k);
        run(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
